speaker_tone_serializer: RTL
============================

SPEAKER_TONE_SERIALIZER -- requirements
Module: speaker_tone_serializer

Interface
REQ-001 Parameter DATA_W, default 16, width of one audio sample per channel.
REQ-002 Parameter DIV_W, default 22, width of note half-period inputs.
REQ-003 clk  input  1  global clock, nominal 40 MHz; all logic on posedge clk.
REQ-004 rst  input  1  reset; asynchronous and active-low (rst=0 resets).
REQ-005 volumn  input  DATA_W  tone amplitude from volumn_counter, 16'h8000 + k*2000, k=0..15.
REQ-006 note_div_l  input  DIV_W  left tone half-period in clk cycles; 0 = silence.
REQ-007 note_div_r  input  DIV_W  right tone half-period; present only with SPK_DUAL_TONE_EN.
REQ-008 mute  input  1  forces silence on both channels.
REQ-009 mclk  output  1  DAC master clock, clk/4.
REQ-010 lrck  output  1  channel select, clk/512; 0 = left, 1 = right.
REQ-011 sck  output  1  serial bit clock, clk/16.
REQ-012 sdin  output  1  serial data, MSB first, valid on sck rising edge.
REQ-013 frame_start  output  1  one-clk pulse when a new stereo frame is loaded.

Function
REQ-014 Free-running 9-bit divider cnt increments every clk and wraps 511 -> 0; mclk=cnt[1], sck=cnt[3], lrck=cnt[8], all registered.
REQ-015 Per channel, a tone counter counts 0..note_div-1; on reaching note_div-1 it clears and toggles phase bit b_clk.
REQ-016 If note_div changes and tone counter >= new note_div-1, counter clears and b_clk toggles on the next clk.
REQ-017 note_div==0 holds tone counter and b_clk at 0; channel sample is 16'h0000.
REQ-018 Channel sample = volumn when b_clk=1, ~volumn (bitwise) when b_clk=0, 16'h0000 when mute=1 or note_div==0.
REQ-019 On the clk where cnt==511, a 32-bit shift register loads {left_sample, right_sample} and frame_start pulses on the following cycle (cnt==0).
REQ-020 sdin = shift register MSB; register shifts left by one, zero-filled, on every clk where cnt[3:0]==4'hF, except at cnt==511 (load wins).
REQ-021 Samples are captured only at frame load; volumn/mute/note_div changes mid-frame never alter bits already in flight.
REQ-022 Left sample occupies lrck=0 half (cnt 0..255), right sample lrck=1 half (cnt 256..511), MSB at half start.

Reset
REQ-023 rst=0 asynchronously clears cnt, tone counters, b_clk, shift register, mclk, lrck, sck, sdin, frame_start to 0.
REQ-024 Reset asserted mid-frame abandons the frame; first frame after release starts at cnt=0 shifting all zeros, first real load at cnt==511.

Configuration
REQ-025 Macro SPK_DUAL_TONE_EN defined: note_div_r port exists, right channel has its own tone counter/b_clk.
REQ-026 SPK_DUAL_TONE_EN undefined: no note_div_r port, right sample equals left sample every frame.

Structure
REQ-027 Shared package spk_pkg holds FRAME_LEN=512, SCK_DIV=16, MCLK_DIV=4, SILENCE_SAMPLE=16'h0000, DATA_W/DIV_W defaults.
REQ-028 Sub-module tone_square_gen (tone counter + b_clk + sample select), instantiated once or twice per SPK_DUAL_TONE_EN.

Verification
REQ-029 Hold rst=0 10 cycles then release -> all outputs 0 during reset; thereafter mclk period 4, sck period 16, lrck period 512 clk.
REQ-030 volumn=16'hF530, note_div_l=100000, mute=0 -> first full frame shifts 0x0ACF/0x0ACF; frames after 100000 clk shift 0xF530/0xF530.
REQ-031 mute raised at cnt==100 -> current frame bits unchanged; next frame shifts 0x0000/0x0000; frame_start pulses once per 512 clk.
REQ-032 note_div_l=0 -> every frame 0x0000/0x0000, b_clk constant 0.
REQ-033 note_div_l switched 100000 -> 10 with tone counter at 50000 -> b_clk toggles next clk, then every 10 clk.
REQ-034 SPK_DUAL_TONE_EN, note_div_l=0, note_div_r=100000, volumn=16'h8000 -> left 0x0000, right alternates 0x7FFF/0x8000 by phase.

Source files
------------

// File: rtl/spk_pkg.sv
// Shared constants for the speaker tone serializer: frame geometry, clock
// divider ratios and default widths.
package spk_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DIV_W_DEF  = 22;

  localparam int FRAME_LEN = 512;
  localparam int SCK_DIV   = 16;
  localparam int MCLK_DIV  = 4;

  localparam logic [15:0] SILENCE_SAMPLE = 16'h0000;

  // Divider bit positions derived from the ratios above.
  localparam int CNT_W    = $clog2(FRAME_LEN);
  localparam int MCLK_BIT = $clog2(MCLK_DIV) - 1;
  localparam int SCK_BIT  = $clog2(SCK_DIV) - 1;
  localparam int LRCK_BIT = CNT_W - 1;

endpackage

// File: rtl/tone_square_gen.sv
// Square-wave tone source: half-period counter, phase bit and the sample
// select between volumn, ~volumn and silence.
module tone_square_gen
  import spk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] volumn,
  input  logic [DIV_W-1:0]  note_div,
  input  logic              mute,
  output logic [DATA_W-1:0] sample
);

  logic [DIV_W-1:0] tone_cnt;
  logic             b_clk;
  logic             silent;

  assign silent = (note_div == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_cnt <= '0;
      b_clk    <= 1'b0;
    end else if (silent) begin
      tone_cnt <= '0;
      b_clk    <= 1'b0;
    end else if (tone_cnt >= note_div - DIV_W'(1)) begin
      // >= so that a shortened half-period takes effect on the very next clk
      tone_cnt <= '0;
      b_clk    <= ~b_clk;
    end else begin
      tone_cnt <= tone_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    sample = DATA_W'(SILENCE_SAMPLE);
    if (!mute && !silent) begin
      sample = b_clk ? volumn : ~volumn;
    end
  end

endmodule

// File: rtl/speaker_tone_serializer.sv
// Tone-to-DAC serializer: free-running frame divider, per-frame sample load
// and MSB-first shift-out. Define SPK_DUAL_TONE_EN for an independent right tone.
module speaker_tone_serializer
  import spk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] volumn,
  input  logic [DIV_W-1:0]  note_div_l,
`ifdef SPK_DUAL_TONE_EN
  input  logic [DIV_W-1:0]  note_div_r,
`endif
  input  logic              mute,
  output logic              mclk,
  output logic              lrck,
  output logic              sck,
  output logic              sdin,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [2*DATA_W-1:0] shreg;
  logic [DATA_W-1:0]   left_sample;
  logic [DATA_W-1:0]   right_sample;
  logic                frame_load;
  logic                bit_shift;

  tone_square_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_tone_l (
    .clk      (clk),
    .rst      (rst),
    .volumn   (volumn),
    .note_div (note_div_l),
    .mute     (mute),
    .sample   (left_sample)
  );

`ifdef SPK_DUAL_TONE_EN
  tone_square_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_tone_r (
    .clk      (clk),
    .rst      (rst),
    .volumn   (volumn),
    .note_div (note_div_r),
    .mute     (mute),
    .sample   (right_sample)
  );
`else
  assign right_sample = left_sample;
`endif

  assign cnt_nxt    = cnt + CNT_W'(1);
  assign frame_load = (cnt == CNT_LAST);
  assign bit_shift  = &cnt[SCK_BIT:0];

  // Clock outputs track cnt_nxt so each one equals the live divider bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      mclk        <= 1'b0;
      sck         <= 1'b0;
      lrck        <= 1'b0;
      frame_start <= 1'b0;
      shreg       <= '0;
    end else begin
      cnt         <= cnt_nxt;
      mclk        <= cnt_nxt[MCLK_BIT];
      sck         <= cnt_nxt[SCK_BIT];
      lrck        <= cnt_nxt[LRCK_BIT];
      frame_start <= frame_load;
      if (frame_load) begin
        shreg <= {left_sample, right_sample};
      end else if (bit_shift) begin
        shreg <= {shreg[2*DATA_W-2:0], 1'b0};
      end
    end
  end

  assign sdin = shreg[2*DATA_W-1];

endmodule
